framebuffer_read_arbiter: RTL and testbench

//  Shares the single framebuffer read port (XRead/YRead -> readValueMemory) between two requesters:
//  VGA scan-out pixel fetch and CPU pixel loads. Fixed VGA priority with a guaranteed CPU slot,

---
 rtl/framebuffer_read_arbiter_pkg.sv | 34 +++
 rtl/framebuffer_read_arbiter_if.sv | 50 +++++
 rtl/framebuffer_read_arbiter_tag_pipe.sv | 35 +++
 rtl/framebuffer_read_arbiter.sv | 169 ++++++++++++++++
 tb/tb_framebuffer_read_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/framebuffer_read_arbiter_pkg.sv
// Shared types and constants for the framebuffer read arbiter.
// Contents:
//   owner_e             - which requester a read in flight belongs to
//   rd_tag_t            - owner plus a "zero the data" flag carried alongside each read
//   X_W / Y_W           - framebuffer coordinate widths
//   coord_out_of_range  - unsigned range check of a coordinate against the image size
package asip_fb_pkg;

    localparam int X_W = 9;
    localparam int Y_W = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_e;

    // err means "return zero data". It is reported to the CPU as an error;
    // for VGA it just produces a blanking pixel.
    typedef struct packed {
        owner_e owner;
        logic   err;
    } rd_tag_t;

    function automatic logic coord_out_of_range(
        input logic [X_W-1:0] x,
        input logic [Y_W-1:0] y,
        input int unsigned    width,
        input int unsigned    height
    );
        return (32'(x) >= width) || (32'(y) >= height);
    endfunction

endpackage

// File: rtl/framebuffer_read_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters (VGA scan-out, CPU loads)
// and the framebuffer memory read port.
// Signals:
//   vga_req_valid/ready, vga_x/y        VGA fetch request handshake and coordinate
//   vga_rsp_valid, vga_rsp_data         VGA pixel response strobe and data
//   cpu_req_valid/ready, cpu_x/y        CPU load request handshake and coordinate
//   cpu_rsp_valid, cpu_rsp_data/error   CPU pixel response strobe, data, range error
//   XRead, YRead                        memory read address
//   readValueMemory                     memory read data
// Modports: slave = arbiter side, master = requesters + memory side.
interface framebuffer_read_arbiter_if #(
    parameter int ColorBits = 3
);
    logic                          vga_req_valid;
    logic                          vga_req_ready;
    logic [asip_fb_pkg::X_W-1:0]   vga_x;
    logic [asip_fb_pkg::Y_W-1:0]   vga_y;
    logic                          vga_rsp_valid;
    logic [ColorBits-1:0]          vga_rsp_data;

    logic                          cpu_req_valid;
    logic                          cpu_req_ready;
    logic [asip_fb_pkg::X_W-1:0]   cpu_x;
    logic [asip_fb_pkg::Y_W-1:0]   cpu_y;
    logic                          cpu_rsp_valid;
    logic [ColorBits-1:0]          cpu_rsp_data;
    logic                          cpu_rsp_error;

    logic [asip_fb_pkg::X_W-1:0]   XRead;
    logic [asip_fb_pkg::Y_W-1:0]   YRead;
    logic [ColorBits-1:0]          readValueMemory;

    modport slave (
        input  vga_req_valid, vga_x, vga_y,
        output vga_req_ready, vga_rsp_valid, vga_rsp_data,
        input  cpu_req_valid, cpu_x, cpu_y,
        output cpu_req_ready, cpu_rsp_valid, cpu_rsp_data, cpu_rsp_error,
        output XRead, YRead,
        input  readValueMemory
    );

    modport master (
        output vga_req_valid, vga_x, vga_y,
        input  vga_req_ready, vga_rsp_valid, vga_rsp_data,
        output cpu_req_valid, cpu_x, cpu_y,
        input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_data, cpu_rsp_error,
        input  XRead, YRead,
        output readValueMemory
    );
endinterface

// File: rtl/framebuffer_read_arbiter_tag_pipe.sv
// fb_tag_pipe: delay line for read tags so each tag pops out in the same
// cycle as the memory data of its read.
// The first stage lines up with the registered read address; the remaining
// MemLatency stages cover the memory's own read latency, so a tag loaded at
// edge N is presented during cycle N+MemLatency+1.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low clear (drops every read in flight)
//   tag_in   in   tag of the read granted at this edge
//   tag_out  out  tag whose data is on the memory read port this cycle
module fb_tag_pipe
    import asip_fb_pkg::*;
#(
    parameter int MemLatency = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t [MemLatency:0] stage_r;

    // Shift register of tags; clearing all stages cancels pending responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_r <= '0;
        end else begin
            stage_r <= {stage_r[MemLatency-1:0], tag_in};
        end
    end

    assign tag_out = stage_r[MemLatency];

endmodule

// File: rtl/framebuffer_read_arbiter.sv
// framebuffer_read_arbiter: shares the single framebuffer read port between
// VGA scan-out and CPU pixel loads.
//   - VGA has priority, but after CpuSlotPeriod-1 consecutive VGA grants with
//     the CPU waiting, the CPU takes the next slot.
//   - At most one grant per cycle; the granted coordinate is registered onto
//     XRead/YRead, and a tag travels alongside so the response is steered to
//     the right requester MemLatency+1 cycles after the grant.
//   - Out-of-range coordinates still take a slot and return zero data (CPU
//     additionally sees cpu_rsp_error).
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-low
//   bus    slave modport of framebuffer_read_arbiter_if (requests, responses,
//          memory read address and data)
module framebuffer_read_arbiter
    import asip_fb_pkg::*;
#(
    parameter int          ColorBits     = 3,
    parameter int unsigned ImageWidth    = 10,
    parameter int unsigned ImageHeight   = 5,
    parameter int          MemLatency    = 1,
    parameter int          CpuSlotPeriod = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    framebuffer_read_arbiter_if.slave bus
);

    localparam int StreakW = $clog2(CpuSlotPeriod);

    logic [StreakW-1:0]   streak_r;
    logic [StreakW-1:0]   streak_next_s;
    logic                 streak_sat_s;
    logic                 vga_ready_s;
    logic                 cpu_ready_s;
    logic                 vga_grant_s;
    logic                 cpu_grant_s;
    logic                 vga_oob_s;
    logic                 cpu_oob_s;
    logic [X_W-1:0]       x_r;
    logic [Y_W-1:0]       y_r;
    logic [X_W-1:0]       x_next_s;
    logic [Y_W-1:0]       y_next_s;
    rd_tag_t              tag_in_s;
    rd_tag_t              tag_out_s;
    logic                 vga_rsp_valid_s;
    logic                 cpu_rsp_valid_s;
    logic                 cpu_rsp_error_s;
    logic [ColorBits-1:0] vga_rsp_data_s;
    logic [ColorBits-1:0] cpu_rsp_data_s;

    assign streak_sat_s = (streak_r == StreakW'(CpuSlotPeriod - 1));
    assign vga_oob_s    = coord_out_of_range(bus.vga_x, bus.vga_y, ImageWidth, ImageHeight);
    assign cpu_oob_s    = coord_out_of_range(bus.cpu_x, bus.cpu_y, ImageWidth, ImageHeight);

    // Ready terms look only at the other requester's valid and the streak,
    // never at a requester's own coordinates. Reset forces both low, yet the
    // first edge after release can already grant.
    always_comb begin
        vga_ready_s = 1'b0;
        cpu_ready_s = 1'b0;
        if (reset) begin
            cpu_ready_s = !bus.vga_req_valid || streak_sat_s;
            vga_ready_s = !(bus.cpu_req_valid && streak_sat_s);
        end else begin
            cpu_ready_s = 1'b0;
            vga_ready_s = 1'b0;
        end
    end

    // The two ready terms are mutually exclusive whenever both are valid,
    // so at most one grant fires.
    assign vga_grant_s = bus.vga_req_valid && vga_ready_s;
    assign cpu_grant_s = bus.cpu_req_valid && cpu_ready_s;

    // Streak counts VGA wins while the CPU is waiting and saturates at the slot limit.
    always_comb begin
        streak_next_s = streak_r;
        if (!bus.cpu_req_valid || cpu_grant_s) begin
            streak_next_s = '0;
        end else if (vga_grant_s && !streak_sat_s) begin
            streak_next_s = streak_r + StreakW'(1);
        end else begin
            streak_next_s = streak_r;
        end
    end

    // Next read address and tag; an out-of-range CPU grant leaves the address alone.
    always_comb begin
        x_next_s = x_r;
        y_next_s = y_r;
        tag_in_s = '{owner: OWN_NONE, err: 1'b0};
        if (vga_grant_s) begin
            x_next_s = bus.vga_x;
            y_next_s = bus.vga_y;
            tag_in_s = '{owner: OWN_VGA, err: vga_oob_s};
        end else if (cpu_grant_s) begin
            if (!cpu_oob_s) begin
                x_next_s = bus.cpu_x;
                y_next_s = bus.cpu_y;
            end else begin
                x_next_s = x_r;
                y_next_s = y_r;
            end
            tag_in_s = '{owner: OWN_CPU, err: cpu_oob_s};
        end else begin
            x_next_s = x_r;
            y_next_s = y_r;
            tag_in_s = '{owner: OWN_NONE, err: 1'b0};
        end
    end

    // Address and streak registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_r      <= '0;
            y_r      <= '0;
            streak_r <= '0;
        end else begin
            x_r      <= x_next_s;
            y_r      <= y_next_s;
            streak_r <= streak_next_s;
        end
    end

    fb_tag_pipe #(
        .MemLatency (MemLatency)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (reset),
        .tag_in  (tag_in_s),
        .tag_out (tag_out_s)
    );

    // Steer the memory data to the tag's owner; data is zero unless that strobe is up.
    always_comb begin
        vga_rsp_valid_s = 1'b0;
        cpu_rsp_valid_s = 1'b0;
        cpu_rsp_error_s = 1'b0;
        vga_rsp_data_s  = '0;
        cpu_rsp_data_s  = '0;
        case (tag_out_s.owner)
            OWN_VGA: begin
                vga_rsp_valid_s = 1'b1;
                vga_rsp_data_s  = tag_out_s.err ? '0 : bus.readValueMemory;
            end
            OWN_CPU: begin
                cpu_rsp_valid_s = 1'b1;
                cpu_rsp_error_s = tag_out_s.err;
                cpu_rsp_data_s  = tag_out_s.err ? '0 : bus.readValueMemory;
            end
            default: begin
                vga_rsp_valid_s = 1'b0;
                cpu_rsp_valid_s = 1'b0;
            end
        endcase
    end

    assign bus.vga_req_ready = vga_ready_s;
    assign bus.cpu_req_ready = cpu_ready_s;
    assign bus.vga_rsp_valid = vga_rsp_valid_s;
    assign bus.vga_rsp_data  = vga_rsp_data_s;
    assign bus.cpu_rsp_valid = cpu_rsp_valid_s;
    assign bus.cpu_rsp_data  = cpu_rsp_data_s;
    assign bus.cpu_rsp_error = cpu_rsp_error_s;
    assign bus.XRead         = x_r;
    assign bus.YRead         = y_r;

endmodule

// File: tb/tb_framebuffer_read_arbiter.sv
// Testbench for framebuffer_read_arbiter. Two instances: dut0 with
// MemLatency=1 and dut1 with MemLatency=3, each fed by a registered memory
// model returning pixel (x+y)%8. A reference model checks every cycle of
// both instances; a vector table and hand sequences add fixed expectations.
module tb_framebuffer_read_arbiter;

    logic clk;
    logic rst_n_tb;

    int vga_v [2];
    int vga_x [2];
    int vga_y [2];
    int cpu_v [2];
    int cpu_x [2];
    int cpu_y [2];

    logic       vga_rdy [2];
    logic       cpu_rdy [2];
    logic       vga_rv  [2];
    logic [2:0] vga_rd  [2];
    logic       cpu_rv  [2];
    logic [2:0] cpu_rd  [2];
    logic       cpu_re  [2];
    logic [8:0] xr      [2];
    logic [7:0] yr      [2];

    int n_cmp = 0;
    int n_bad = 0;

    framebuffer_read_arbiter_if #(.ColorBits(3)) bus [2] ();

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int L = (k == 0) ? 1 : 3;
        logic [2:0] m0, m1, m2;

        assign bus[k].vga_req_valid = (vga_v[k] != 0);
        assign bus[k].vga_x         = 9'(vga_x[k]);
        assign bus[k].vga_y         = 8'(vga_y[k]);
        assign bus[k].cpu_req_valid = (cpu_v[k] != 0);
        assign bus[k].cpu_x         = 9'(cpu_x[k]);
        assign bus[k].cpu_y         = 8'(cpu_y[k]);

        assign vga_rdy[k] = bus[k].vga_req_ready;
        assign cpu_rdy[k] = bus[k].cpu_req_ready;
        assign vga_rv[k]  = bus[k].vga_rsp_valid;
        assign vga_rd[k]  = bus[k].vga_rsp_data;
        assign cpu_rv[k]  = bus[k].cpu_rsp_valid;
        assign cpu_rd[k]  = bus[k].cpu_rsp_data;
        assign cpu_re[k]  = bus[k].cpu_rsp_error;
        assign xr[k]      = bus[k].XRead;
        assign yr[k]      = bus[k].YRead;

        // Registered memory: pixel (x+y)%8, L register stages after the address.
        always @(posedge clk) begin
            m0 <= 3'((int'(bus[k].XRead) + int'(bus[k].YRead)) % 8);
            m1 <= m0;
            m2 <= m1;
        end
        assign bus[k].readValueMemory = (L == 1) ? m0 : m2;

        framebuffer_read_arbiter #(
            .ColorBits     (3),
            .ImageWidth    (10),
            .ImageHeight   (5),
            .MemLatency    (L),
            .CpuSlotPeriod (4)
        ) dut (
            .clk   (clk),
            .reset (rst_n_tb),
            .bus   (bus[k])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Expected response per future cycle (slot = cycle % 16): owner 0 none, 1 vga, 2 cpu.
    int cyc = 0;
    int streak_m [2];
    int addr_x_m [2];
    int addr_y_m [2];
    int slot_own [2][16];
    int slot_dat [2][16];
    int slot_err [2][16];

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int s, d, lat, own, oob, cg, vg;
            lat = (k == 0) ? 1 : 3;
            s   = cyc % 16;
            if (!rst_n_tb) begin
                chk($sformatf("dut%0d rst vga_ready", k), int'(vga_rdy[k]), 0);
                chk($sformatf("dut%0d rst cpu_ready", k), int'(cpu_rdy[k]), 0);
                chk($sformatf("dut%0d rst vga_rsp_valid", k), int'(vga_rv[k]), 0);
                chk($sformatf("dut%0d rst cpu_rsp_valid", k), int'(cpu_rv[k]), 0);
                chk($sformatf("dut%0d rst cpu_rsp_error", k), int'(cpu_re[k]), 0);
                chk($sformatf("dut%0d rst XRead", k), int'(xr[k]), 0);
                chk($sformatf("dut%0d rst YRead", k), int'(yr[k]), 0);
                for (int i = 0; i < 16; i++) slot_own[k][i] = 0;
                streak_m[k] = 0;
                addr_x_m[k] = 0;
                addr_y_m[k] = 0;
            end else begin
                own = slot_own[k][s];
                chk($sformatf("dut%0d vga_rsp_valid", k), int'(vga_rv[k]), (own == 1) ? 1 : 0);
                chk($sformatf("dut%0d vga_rsp_data", k), int'(vga_rd[k]), (own == 1) ? slot_dat[k][s] : 0);
                chk($sformatf("dut%0d cpu_rsp_valid", k), int'(cpu_rv[k]), (own == 2) ? 1 : 0);
                chk($sformatf("dut%0d cpu_rsp_data", k), int'(cpu_rd[k]), (own == 2) ? slot_dat[k][s] : 0);
                chk($sformatf("dut%0d cpu_rsp_error", k), int'(cpu_re[k]), (own == 2) ? slot_err[k][s] : 0);
                chk($sformatf("dut%0d XRead", k), int'(xr[k]), addr_x_m[k]);
                chk($sformatf("dut%0d YRead", k), int'(yr[k]), addr_y_m[k]);
                slot_own[k][s] = 0;

                cg = (cpu_v[k] != 0 && (vga_v[k] == 0 || streak_m[k] == 3)) ? 1 : 0;
                vg = (vga_v[k] != 0 && cg == 0) ? 1 : 0;
                chk($sformatf("dut%0d vga_accept", k), (vga_v[k] != 0 && vga_rdy[k]) ? 1 : 0, vg);
                chk($sformatf("dut%0d cpu_accept", k), (cpu_v[k] != 0 && cpu_rdy[k]) ? 1 : 0, cg);

                d = (cyc + lat + 1) % 16;
                if (vg == 1) begin
                    oob = (vga_x[k] >= 10 || vga_y[k] >= 5) ? 1 : 0;
                    slot_own[k][d] = 1;
                    slot_dat[k][d] = oob ? 0 : (vga_x[k] + vga_y[k]) % 8;
                    slot_err[k][d] = 0;
                    addr_x_m[k] = vga_x[k];
                    addr_y_m[k] = vga_y[k];
                end
                if (cg == 1) begin
                    oob = (cpu_x[k] >= 10 || cpu_y[k] >= 5) ? 1 : 0;
                    slot_own[k][d] = 2;
                    slot_dat[k][d] = oob ? 0 : (cpu_x[k] + cpu_y[k]) % 8;
                    slot_err[k][d] = oob;
                    if (oob == 0) begin
                        addr_x_m[k] = cpu_x[k];
                        addr_y_m[k] = cpu_y[k];
                    end
                end
                if (cpu_v[k] == 0 || cg == 1) streak_m[k] = 0;
                else if (vg == 1 && streak_m[k] < 3) streak_m[k] = streak_m[k] + 1;
            end
        end
        cyc++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    // ---------------- directed vectors (dut0) ----------------
    typedef struct {
        int vv, vx, vy, cv, cx, cy;
        int eva, eca;
        int evr, evd;
        int ecr, ecd, ece;
        int exr, eyr;
    } vec_t;

    vec_t tbl [16];

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            vga_v[k] = 0; vga_x[k] = 0; vga_y[k] = 0;
            cpu_v[k] = 0; cpu_x[k] = 0; cpu_y[k] = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n_tb = 1'b1;
        idle_all();
        tbl[0]  = '{1,0,0,  0,0,0,  1,0, 0,0, 0,0,0, 0,0};
        tbl[1]  = '{1,1,0,  0,0,0,  1,0, 0,0, 0,0,0, 0,0};
        tbl[2]  = '{1,2,0,  0,0,0,  1,0, 1,0, 0,0,0, 1,0};
        tbl[3]  = '{0,0,0,  0,0,0,  0,0, 1,1, 0,0,0, 2,0};
        tbl[4]  = '{0,0,0,  0,0,0,  0,0, 1,2, 0,0,0, 2,0};
        tbl[5]  = '{1,0,1,  1,3,2,  1,0, 0,0, 0,0,0, 2,0};
        tbl[6]  = '{1,1,1,  1,3,2,  1,0, 0,0, 0,0,0, 0,1};
        tbl[7]  = '{1,2,1,  1,3,2,  1,0, 1,1, 0,0,0, 1,1};
        tbl[8]  = '{1,3,1,  1,3,2,  0,1, 1,2, 0,0,0, 2,1};
        tbl[9]  = '{1,4,1,  0,0,0,  1,0, 1,3, 0,0,0, 3,2};
        tbl[10] = '{0,0,0,  1,9,4,  0,1, 0,0, 1,5,0, 4,1};
        tbl[11] = '{0,0,0,  1,10,0, 0,1, 1,5, 0,0,0, 9,4};
        tbl[12] = '{1,12,7, 0,0,0,  1,0, 0,0, 1,5,0, 9,4};
        tbl[13] = '{0,0,0,  0,0,0,  0,0, 0,0, 1,0,1, 12,7};
        tbl[14] = '{0,0,0,  0,0,0,  0,0, 1,0, 0,0,0, 12,7};
        tbl[15] = '{0,0,0,  0,0,0,  0,0, 0,0, 0,0,0, 12,7};

        #2 rst_n_tb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Release reset together with the first request.
        rst_n_tb = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step();
            vga_v[0] = tbl[i].vv; vga_x[0] = tbl[i].vx; vga_y[0] = tbl[i].vy;
            cpu_v[0] = tbl[i].cv; cpu_x[0] = tbl[i].cx; cpu_y[0] = tbl[i].cy;
            @(negedge clk);
            chk($sformatf("tbl%0d vga_accept", i), (vga_v[0] != 0 && vga_rdy[0]) ? 1 : 0, tbl[i].eva);
            chk($sformatf("tbl%0d cpu_accept", i), (cpu_v[0] != 0 && cpu_rdy[0]) ? 1 : 0, tbl[i].eca);
            chk($sformatf("tbl%0d vga_rsp_valid", i), int'(vga_rv[0]), tbl[i].evr);
            chk($sformatf("tbl%0d vga_rsp_data", i), int'(vga_rd[0]), tbl[i].evd);
            chk($sformatf("tbl%0d cpu_rsp_valid", i), int'(cpu_rv[0]), tbl[i].ecr);
            chk($sformatf("tbl%0d cpu_rsp_data", i), int'(cpu_rd[0]), tbl[i].ecd);
            chk($sformatf("tbl%0d cpu_rsp_error", i), int'(cpu_re[0]), tbl[i].ece);
            chk($sformatf("tbl%0d XRead", i), int'(xr[0]), tbl[i].exr);
            chk($sformatf("tbl%0d YRead", i), int'(yr[0]), tbl[i].eyr);
        end

        // Reset the cycle after a CPU grant: read dropped, outputs cleared at once.
        step();
        idle_all();
        cpu_v[0] = 1; cpu_x[0] = 2; cpu_y[0] = 3;
        step();
        cpu_v[0] = 0;
        rst_n_tb = 1'b0;
        @(negedge clk);
        chk("rst5 cpu_rsp_valid", int'(cpu_rv[0]), 0);
        chk("rst5 XRead", int'(xr[0]), 0);
        chk("rst5 YRead", int'(yr[0]), 0);
        step();
        step();
        rst_n_tb = 1'b1;
        cpu_v[0] = 1; cpu_x[0] = 1; cpu_y[0] = 1;
        step();
        cpu_v[0] = 0;
        @(negedge clk);
        chk("rst5 no early rsp", int'(cpu_rv[0]), 0);
        @(negedge clk);
        chk("rst5 new rsp valid", int'(cpu_rv[0]), 1);
        chk("rst5 new rsp data", int'(cpu_rd[0]), 2);
        chk("rst5 new rsp error", int'(cpu_re[0]), 0);

        // MemLatency=3 instance: alternate V/C grants, each response 4 cycles later.
        step();
        idle_all();
        fork
            begin
                for (int j = 0; j < 6; j++) begin
                    if (j > 0) step();
                    if (j % 2 == 0) begin
                        vga_v[1] = 1; vga_x[1] = j; vga_y[1] = 1;
                        cpu_v[1] = 0;
                    end else begin
                        cpu_v[1] = 1; cpu_x[1] = j; cpu_y[1] = 2;
                        vga_v[1] = 0;
                    end
                end
                step();
                idle_all();
            end
            begin
                for (int t = 0; t < 10; t++) begin
                    @(negedge clk);
                    if (t >= 4) begin
                        if ((t - 4) % 2 == 0) begin
                            chk($sformatf("lat3 g%0d vga_rsp_valid", t - 4), int'(vga_rv[1]), 1);
                            chk($sformatf("lat3 g%0d vga_rsp_data", t - 4), int'(vga_rd[1]), (t - 4 + 1) % 8);
                            chk($sformatf("lat3 g%0d cpu_quiet", t - 4), int'(cpu_rv[1]), 0);
                        end else begin
                            chk($sformatf("lat3 g%0d cpu_rsp_valid", t - 4), int'(cpu_rv[1]), 1);
                            chk($sformatf("lat3 g%0d cpu_rsp_data", t - 4), int'(cpu_rd[1]), (t - 4 + 2) % 8);
                            chk($sformatf("lat3 g%0d vga_quiet", t - 4), int'(vga_rv[1]), 0);
                        end
                    end else begin
                        chk($sformatf("lat3 early t%0d", t), int'(vga_rv[1]) + int'(cpu_rv[1]), 0);
                    end
                end
            end
        join

        // Randomised traffic on both instances, checked by the reference model.
        for (int n = 0; n < 400; n++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                vga_v[k] = ($urandom_range(0, 3) != 0) ? 1 : 0;
                vga_x[k] = int'($urandom_range(0, 11));
                vga_y[k] = int'($urandom_range(0, 6));
                cpu_v[k] = int'($urandom_range(0, 1));
                cpu_x[k] = int'($urandom_range(0, 11));
                cpu_y[k] = int'($urandom_range(0, 6));
            end
        end
        step();
        idle_all();
        repeat (6) @(posedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
